exception_arbiter: RTL

EXCEPTION_ARBITER -- requirements
Module: exception_arbiter

---
 rtl/exception_arbiter.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/exception_arbiter.sv
// exception_arbiter
//
// Picks the single winning event among an external interrupt, the per-stage
// pipeline exceptions (IF/ID/EX/MEM) and an ERET in MEM. It then walks the
// pipeline through a one-cycle FLUSH and a DRAIN_CYCLES-long DRAIN before it
// accepts new requests. It also owns the CP0 Count/Compare timer, which
// produces interrupt line IP7.
//
// Optional feature macro: EXCEPTION_ARBITER_TIMER_EN
//   defined   : Count/Compare timer is built, timer_interrupt feeds IP7.
//   undefined : timer_interrupt and count_value are tied to 0.
//               count_write and compare_write are ignored.
//
// Ports
//   clock, reset            rising-edge clock, synchronous active-high reset
//   stage_exception_valid   per-stage request (bit0 IF .. bit3 MEM)
//   stage_exception_code    5-bit ExcCode per stage, stage i at [5i+4:5i]
//   stage_pc                32-bit PC per stage, stage i at [32i+31:32i]
//   stage_in_delay_slot     delay-slot flag per stage
//   mem_valid               MEM holds a real instruction
//   eret_request, epc       ERET in MEM and its return target
//   status_ie, status_exl   Status.IE / Status.EXL
//   interrupt_mask          Status.IM
//   pending_interrupt       {hw[5:0], sw[1:0]} before the timer merge
//   count_write, compare_write, write_data   MTC0 writes to Count / Compare
//   flush, redirect_pc      flush pulse and new fetch target
//   commit_exception_valid, commit_eret      CP0 update pulses
//   commit_exception_code, commit_pc, commit_in_delay_slot   committed data
//   busy                    high during FLUSH and DRAIN
//   timer_interrupt, count_value             IP7 and current Count
module exception_arbiter #(
    parameter logic [31:0] EXCEPTION_VECTOR = 32'hbfc00380,
    parameter int          DRAIN_CYCLES     = 2
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [3:0]   stage_exception_valid,
    input  logic [19:0]  stage_exception_code,
    input  logic [127:0] stage_pc,
    input  logic [3:0]   stage_in_delay_slot,
    input  logic         mem_valid,
    input  logic         eret_request,
    input  logic [31:0]  epc,
    input  logic         status_ie,
    input  logic         status_exl,
    input  logic [7:0]   interrupt_mask,
    input  logic [7:0]   pending_interrupt,
    input  logic         count_write,
    input  logic         compare_write,
    input  logic [31:0]  write_data,
    output logic         flush,
    output logic [31:0]  redirect_pc,
    output logic         commit_exception_valid,
    output logic         commit_eret,
    output logic [4:0]   commit_exception_code,
    output logic [31:0]  commit_pc,
    output logic         commit_in_delay_slot,
    output logic         busy,
    output logic         timer_interrupt,
    output logic [31:0]  count_value
);

    typedef enum logic [1:0] {IDLE, FLUSH, DRAIN} state_t;

    state_t      state_q;
    logic [3:0]  drainCnt_q;
    logic        flush_q;
    logic [31:0] redirect_q;
    logic        commitExc_q;
    logic        commitEret_q;
    logic [4:0]  commitCode_q;
    logic [31:0] commitPc_q;
    logic        commitBd_q;
    logic        busy_q;
    logic        timerIrq;

    logic [7:0]  pendingEff;
    logic        interruptTaken;
    logic        winTake;
    logic        winEret;
    logic [4:0]  winCode;
    logic [31:0] winPc;
    logic        winBd;

`ifdef EXCEPTION_ARBITER_TIMER_EN
    logic [31:0] count_q;
    logic [31:0] count_d;
    logic [31:0] compare_q;
    logic        toggle_q;
    logic        toggle_d;
    logic        timer_q;

    // Count advances on every second clock. An MTC0 write to Count
    // overrides the increment and restarts the half-rate phase.
    always_comb begin
        count_d  = count_q;
        toggle_d = ~toggle_q;
        if (count_write) begin
            count_d  = write_data;
            toggle_d = 1'b0;
        end else if (toggle_q) begin
            count_d = count_q + 32'd1;
        end
    end

    // The match is checked against the updated Count. A Compare write
    // acknowledges the interrupt and takes precedence over a match in
    // the same cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q   <= 32'd0;
            compare_q <= 32'd0;
            toggle_q  <= 1'b0;
            timer_q   <= 1'b0;
        end else begin
            count_q  <= count_d;
            toggle_q <= toggle_d;
            if (compare_write) begin
                compare_q <= write_data;
                timer_q   <= 1'b0;
            end else if (count_d == compare_q) begin
                timer_q <= 1'b1;
            end
        end
    end

    assign timerIrq    = timer_q;
    assign count_value = count_q;
`else
    logic unusedTimerInputs;
    assign unusedTimerInputs = ^{count_write, compare_write, write_data};
    assign timerIrq          = 1'b0;
    assign count_value       = 32'd0;
`endif

    assign pendingEff     = {pending_interrupt[7] | timerIrq, pending_interrupt[6:0]};
    assign interruptTaken = status_ie & ~status_exl & mem_valid
                          & (|(interrupt_mask & pendingEff));

    // Winner selection. An interrupt is charged to the instruction in MEM.
    // After that, the oldest stage wins. ERET only counts when no exception
    // is pending.
    always_comb begin
        winTake = 1'b0;
        winEret = 1'b0;
        winCode = 5'd0;
        winPc   = 32'd0;
        winBd   = 1'b0;
        if (interruptTaken) begin
            winTake = 1'b1;
            winPc   = stage_pc[127:96];
            winBd   = stage_in_delay_slot[3];
        end else if (stage_exception_valid[3]) begin
            winTake = 1'b1;
            winCode = stage_exception_code[19:15];
            winPc   = stage_pc[127:96];
            winBd   = stage_in_delay_slot[3];
        end else if (stage_exception_valid[2]) begin
            winTake = 1'b1;
            winCode = stage_exception_code[14:10];
            winPc   = stage_pc[95:64];
            winBd   = stage_in_delay_slot[2];
        end else if (stage_exception_valid[1]) begin
            winTake = 1'b1;
            winCode = stage_exception_code[9:5];
            winPc   = stage_pc[63:32];
            winBd   = stage_in_delay_slot[1];
        end else if (stage_exception_valid[0]) begin
            winTake = 1'b1;
            winCode = stage_exception_code[4:0];
            winPc   = stage_pc[31:0];
            winBd   = stage_in_delay_slot[0];
        end else if (eret_request) begin
            winEret = 1'b1;
        end
    end

    // Sequencer. Requests are only looked at in IDLE. Pulse outputs are set
    // on entry to FLUSH and cleared when leaving it. Commit data and
    // redirect_pc keep their values until the next FLUSH. The commit
    // data is only rewritten by exceptions, not by ERET.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            drainCnt_q   <= 4'd0;
            flush_q      <= 1'b0;
            redirect_q   <= EXCEPTION_VECTOR;
            commitExc_q  <= 1'b0;
            commitEret_q <= 1'b0;
            commitCode_q <= 5'd0;
            commitPc_q   <= 32'd0;
            commitBd_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (winTake) begin
                        state_q      <= FLUSH;
                        flush_q      <= 1'b1;
                        busy_q       <= 1'b1;
                        commitExc_q  <= 1'b1;
                        commitCode_q <= winCode;
                        commitPc_q   <= winPc;
                        commitBd_q   <= winBd;
                        redirect_q   <= EXCEPTION_VECTOR;
                    end else if (winEret) begin
                        state_q      <= FLUSH;
                        flush_q      <= 1'b1;
                        busy_q       <= 1'b1;
                        commitEret_q <= 1'b1;
                        redirect_q   <= epc;
                    end
                end
                FLUSH: begin
                    state_q      <= DRAIN;
                    flush_q      <= 1'b0;
                    commitExc_q  <= 1'b0;
                    commitEret_q <= 1'b0;
                    drainCnt_q   <= 4'(DRAIN_CYCLES - 1);
                end
                DRAIN: begin
                    if (drainCnt_q == 4'd0) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        drainCnt_q <= drainCnt_q - 4'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign flush                  = flush_q;
    assign redirect_pc            = redirect_q;
    assign commit_exception_valid = commitExc_q;
    assign commit_eret            = commitEret_q;
    assign commit_exception_code  = commitCode_q;
    assign commit_pc              = commitPc_q;
    assign commit_in_delay_slot   = commitBd_q;
    assign busy                   = busy_q;
    assign timer_interrupt        = timerIrq;

endmodule
